// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor.
// State encoding, default width and counter sizing.
package serial_subtractor_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor: diff = x - y - bin.
// Ports: x, y, bin in; diff, bout out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial d = a - b, LSB first, with valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready/a/b, out_valid/out_ready/d/borrow/ovf/zero.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = cnt_w(WIDTH);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_nx;
    logic             am_q;
    logic             bm_q;
    logic             bff_q;
    logic [CW-1:0]    cnt_q;
    logic             last;
    logic             accept;
    logic             fs_diff;
    logic             fs_bout;

    logic [WIDTH-1:0] d_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             zero_q;

    full_subtractor u_fs (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (bff_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    assign accept = (state_q == IDLE) && in_valid;
    assign last   = (cnt_q == CW'(WIDTH - 1));
    // New bit enters at the MSB so the LSB-first stream lands in place.
    assign res_nx = {fs_diff, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            am_q     <= 1'b0;
            bm_q     <= 1'b0;
            bff_q    <= 1'b0;
            cnt_q    <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            am_q  <= a[WIDTH-1];
            bm_q  <= b[WIDTH-1];
            bff_q <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == SHIFT) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= res_nx;
            bff_q <= fs_bout;
            cnt_q <= cnt_q + CW'(1);
            // Results load on the final shift edge so they are
            // ready the same cycle out_valid rises.
            if (last) begin
                d_q      <= res_nx;
                borrow_q <= fs_bout;
                ovf_q    <= (am_q ^ bm_q) & (fs_diff ^ am_q);
                zero_q   <= ~|res_nx;
            end
        end
    end

    assign d      = d_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule
